// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg
//   Shared types for the register-file write-back slice: register address,
//   write request record, write source tag and the hard-wired zero register.
package rf_wb_pkg;

  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_BITS  = 64;
  localparam int unsigned RF_AW    = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0] regaddr_t;

  typedef struct packed {
    regaddr_t           addr;
    logic [RF_BITS-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_e;

  localparam regaddr_t ZERO_REG = '0;

  // x0 is hard-wired: writes to it are swallowed, never tracked.
  function automatic logic is_zero_reg(input regaddr_t a);
    return a == ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo
//   QDEPTH-entry circular buffer of wb_req_t used to park load returns that
//   lost write-port arbitration. The caller must not push when full or pop
//   when empty.
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (empties the buffer)
//   push_i       write push_data_i at the tail
//   push_data_i  entry to enqueue
//   pop_i        drop the head entry
//   head_o       current head entry (valid when !empty_o)
//   empty_o      no entries held
//   full_o       QDEPTH entries held
//   count_o      number of entries held
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  wb_req_t                   push_data_i,
  input  logic                      pop_i,
  output wb_req_t                   head_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [$clog2(QDEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  wb_req_t         mem_q [QDEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // QDEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count guards every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl
//   Write-side initiator for the register file. Merges single-cycle ALU
//   results and valid/ready load returns onto one registered write port,
//   queues loads that lose arbitration, and tracks registers awaiting a load.
//   Optional feature macro: RF_BYPASS_EN adds a write-to-read forwarding mux.
// Ports
//   clk, rst_n               clock / asynchronous active-low reset
//   aluValid/aluAddr/aluData ALU result (always accepted, no ready)
//   memValid/memReady        load return handshake
//   memAddr/memData          load destination and data
//   issueValid/issueAddr     load issued; mark destination pending
//   addressw/writeData       register-file write address / data (registered)
//   writeEn                  register-file write enable, one cycle per write
//   pendingMask              bit i set while register i awaits a load
//   queueCount               entries held in the load-return queue
//   rdAddr1/2, rfRead1/2,    (RF_BYPASS_EN only) read addresses, raw file
//   fwdData1/2                read data and forwarded read data
module rf_writeback_ctrl
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned BITS   = 64,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aluValid,
  input  logic [$clog2(DEPTH)-1:0]   aluAddr,
  input  logic [BITS-1:0]            aluData,
  input  logic                       memValid,
  output logic                       memReady,
  input  logic [$clog2(DEPTH)-1:0]   memAddr,
  input  logic [BITS-1:0]            memData,
  input  logic                       issueValid,
  input  logic [$clog2(DEPTH)-1:0]   issueAddr,
`ifdef RF_BYPASS_EN
  input  logic [$clog2(DEPTH)-1:0]   rdAddr1,
  input  logic [$clog2(DEPTH)-1:0]   rdAddr2,
  input  logic [BITS-1:0]            rfRead1,
  input  logic [BITS-1:0]            rfRead2,
  output logic [BITS-1:0]            fwdData1,
  output logic [BITS-1:0]            fwdData2,
`endif
  output logic [$clog2(DEPTH)-1:0]   addressw,
  output logic [BITS-1:0]            writeData,
  output logic                       writeEn,
  output logic [DEPTH-1:0]           pendingMask,
  output logic [$clog2(QDEPTH):0]    queueCount
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  // Queue interface
  wb_req_t          q_head;
  logic             q_empty;
  logic             q_full;
  logic             q_push;
  logic             q_pop;
  logic [CW-1:0]    q_count;

  // Arbitration
  wb_req_t          alu_req;
  wb_req_t          mem_req;
  wb_req_t          sel_req;
  wb_src_e          sel_src;
  logic             mem_acc;
  logic             alu_take;
  logic             mem_take;

  // Output register stage and scoreboard
  logic             wen_q, wen_d;
  regaddr_t         waddr_q, waddr_d;
  logic [BITS-1:0]  wdata_q, wdata_d;
  logic [DEPTH-1:0] pend_q, pend_d;

  assign alu_req = '{addr: aluAddr, data: aluData};
  assign mem_req = '{addr: memAddr, data: memData};

  // Ready depends on occupancy only, so a full queue refuses a new load even
  // in a cycle where its head drains.
  assign memReady = ~q_full;
  assign mem_acc  = memValid & memReady;

  // Writes to x0 are consumed here and never reach the port or the queue.
  assign alu_take = aluValid & ~is_zero_reg(aluAddr);
  assign mem_take = mem_acc  & ~is_zero_reg(memAddr);

  // Priority: ALU, then queued load, then incoming load falling through an
  // empty queue. An accepted load that is not written directly is queued.
  always_comb begin
    sel_src = WB_NONE;
    sel_req = '0;
    q_pop   = 1'b0;
    q_push  = 1'b0;
    if (alu_take) begin
      sel_src = WB_ALU;
      sel_req = alu_req;
      q_push  = mem_take;
    end else if (!q_empty) begin
      sel_src = WB_MEM;
      sel_req = q_head;
      q_pop   = 1'b1;
      q_push  = mem_take;
    end else if (mem_take) begin
      sel_src = WB_MEM;
      sel_req = mem_req;
    end
  end

  rf_wb_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (q_push),
    .push_data_i (mem_req),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .empty_o     (q_empty),
    .full_o      (q_full),
    .count_o     (q_count)
  );

  // Address/data hold their last value when nothing is selected.
  always_comb begin
    wen_d   = (sel_src != WB_NONE);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (sel_src != WB_NONE) begin
      waddr_d = sel_req.addr;
      wdata_d = sel_req.data;
    end
  end

  // The clear is computed at selection so the bit drops on the same edge
  // that raises writeEn. The set is applied last so it wins a collision.
  always_comb begin
    pend_d = pend_q;
    if (sel_src == WB_MEM) pend_d[sel_req.addr] = 1'b0;
    if (issueValid && !is_zero_reg(issueAddr)) pend_d[issueAddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end

  assign writeEn     = wen_q;
  assign addressw    = waddr_q;
  assign writeData   = wdata_q;
  assign pendingMask = pend_q;
  assign queueCount  = q_count;

`ifdef RF_BYPASS_EN
  // Forward the write currently on the port to a same-cycle reader.
  always_comb begin
    fwdData1 = rfRead1;
    fwdData2 = rfRead2;
    if (wen_q && (waddr_q == rdAddr1) && !is_zero_reg(rdAddr1)) fwdData1 = wdata_q;
    if (wen_q && (waddr_q == rdAddr2) && !is_zero_reg(rdAddr2)) fwdData2 = wdata_q;
  end
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb_rf_writeback_ctrl
//   Scoreboard bench for rf_writeback_ctrl (default build, RF_BYPASS_EN off).
//   The stimulus process drives inputs on the falling edge and predicts
//   writes with a queue-based reference model; a monitor process checks
//   every write presented on the port against the expected-write queue.
module tb_rf_writeback_ctrl;

  localparam int unsigned QD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aluValid = 1'b0;
  logic [4:0]  aluAddr = '0;
  logic [63:0] aluData = '0;
  logic        memValid = 1'b0;
  logic        memReady;
  logic [4:0]  memAddr = '0;
  logic [63:0] memData = '0;
  logic        issueValid = 1'b0;
  logic [4:0]  issueAddr = '0;
  logic [4:0]  addressw;
  logic [63:0] writeData;
  logic        writeEn;
  logic [31:0] pendingMask;
  logic [2:0]  queueCount;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(
    .DEPTH  (32),
    .BITS   (64),
    .QDEPTH (QD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .aluValid    (aluValid),
    .aluAddr     (aluAddr),
    .aluData     (aluData),
    .memValid    (memValid),
    .memReady    (memReady),
    .memAddr     (memAddr),
    .memData     (memData),
    .issueValid  (issueValid),
    .issueAddr   (issueAddr),
    .addressw    (addressw),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .pendingMask (pendingMask),
    .queueCount  (queueCount)
  );

  typedef struct {
    int unsigned due;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } ld_t;

  exp_t        exp_q[$];
  ld_t         model_q[$];
  logic [31:0] model_pend = '0;
  logic [4:0]  model_addr = '0;
  logic [63:0] model_data = '0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every write on the port must match the oldest expected write,
  // arriving exactly on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (writeEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("writeEn_idle", 64'(writeEn), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.due));
          check("write_addr", 64'(addressw), 64'(e.addr));
          check("write_data", writeData, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("writeEn_missing", 64'(writeEn), 64'd1);
      end
    end
  end

  // One clock of stimulus: check registered state against the model, drive
  // the inputs, then advance the model by the write-port rules.
  task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [63:0] md,
                       input logic iv, input logic [4:0] ia);
    bit  acc;
    bit  have;
    bit  is_load;
    ld_t w;
    ld_t ld;
    @(negedge clk);
    check("memReady", 64'(memReady), 64'(model_q.size() < QD));
    check("queueCount", 64'(queueCount), 64'(model_q.size()));
    check("pendingMask", 64'(pendingMask), 64'(model_pend));
    check("addressw_hold", 64'(addressw), 64'(model_addr));
    check("writeData_hold", writeData, model_data);
    aluValid = av; aluAddr = aa; aluData = ad;
    memValid = mv; memAddr = ma; memData = md;
    issueValid = iv; issueAddr = ia;

    acc     = mv && (model_q.size() < QD) && (ma != 5'd0);
    ld      = '{addr: ma, data: md};
    have    = 1'b0;
    is_load = 1'b0;
    if (av && aa != 5'd0) begin
      w = '{addr: aa, data: ad};
      have = 1'b1;
    end else if (model_q.size() > 0) begin
      w = model_q.pop_front();
      have = 1'b1;
      is_load = 1'b1;
    end else if (acc) begin
      w = ld;
      have = 1'b1;
      is_load = 1'b1;
      acc = 1'b0;
    end
    if (acc) model_q.push_back(ld);
    if (have) begin
      exp_q.push_back('{due: cyc + 1, addr: w.addr, data: w.data});
      model_addr = w.addr;
      model_data = w.data;
      if (is_load) model_pend[w.addr] = 1'b0;
    end
    if (iv && ia != 5'd0) model_pend[ia] = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Mid-operation reset: everything queued or in flight is dropped.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    aluValid = 1'b0; memValid = 1'b0; issueValid = 1'b0;
    model_q.delete();
    exp_q.delete();
    model_pend = '0;
    model_addr = '0;
    model_data = '0;
    #1;
    check("rst_writeEn", 64'(writeEn), 64'd0);
    check("rst_addressw", 64'(addressw), 64'd0);
    check("rst_writeData", writeData, 64'd0);
    check("rst_pendingMask", 64'(pendingMask), 64'd0);
    check("rst_queueCount", 64'(queueCount), 64'd0);
    check("rst_memReady", 64'(memReady), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 6));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    do_reset();

    // Single ALU write and its idle follow-up.
    drive(1, 5'd5, 64'h1234, 0, 0, 0, 0, 0);
    idle(2);

    // ALU and load together: load waits one cycle in the queue.
    drive(1, 5'd3, 64'h33, 1, 5'd7, 64'hAA, 0, 0);
    idle(3);

    // Issue then return: pending bit held until the write.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
    idle(2);
    drive(0, 0, 0, 1, 5'd9, 64'hBEEF, 0, 0);
    idle(2);

    // Fill the queue behind a busy ALU, then drain in order.
    for (int i = 0; i < 5; i++)
      drive(1, 5'(20 + i), 64'(i), 1, 5'(10 + i), 64'(16'hA000 + i), 1, 5'(10 + i));
    while (model_q.size() >= QD) drive(0, 0, 0, 1, 5'd14, 64'hA004, 0, 0);
    drive(0, 0, 0, 1, 5'd14, 64'hA004, 0, 0);
    idle(6);

    // Writes to x0 are discarded everywhere.
    drive(1, 5'd0, 64'hFF, 1, 5'd0, 64'hFF, 1, 5'd0);
    drive(0, 0, 0, 1, 5'd0, 64'h11, 0, 0);
    idle(2);

    // Set and clear of the same bit in one cycle: set wins.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd4);
    drive(0, 0, 0, 1, 5'd4, 64'h44, 1, 5'd4);
    idle(2);

    // Reset with three loads queued and a write in flight.
    for (int i = 0; i < 3; i++)
      drive(1, 5'd2, 64'(i), 1, 5'(16 + i), 64'(i), 1, 5'(16 + i));
    do_reset();
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      d = {$urandom, $urandom};
      drive($urandom_range(0, 1) == 1, rnd_addr(), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, rnd_addr(), d,
            $urandom_range(0, 2) == 0, rnd_addr());
      if (i == 1000) do_reset();
    end
    idle(10);
    check("expected_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
